// File: rtl/radix_2_pair_reorder.sv
// Ping-pong frame reorder feeding radix_2_butterfly. A natural-order stream
// of complex samples (re in the upper half, im in the lower half) is buffered
// per frame and re-emitted as x0, x(N/2), x1, x(N/2+1), ..., x(N/2-1), x(N-1).

module radix_2_pair_reorder #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_LEN  = 16
) (
  input  logic                    clkIn,
  input  logic                    rstIn,
  input  logic                    enIn,
  input  logic [2*DATA_WIDTH-1:0] dataIn,
  input  logic                    validIn,
  output logic [2*DATA_WIDTH-1:0] dataOut,
  output logic                    validOut,
  output logic                    sofOut
);

  localparam int WORD_W = 2 * DATA_WIDTH;
  localparam int ADDR_W = $clog2(FRAME_LEN);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] HALF_IDX = ADDR_W'(FRAME_LEN / 2);

  typedef enum logic [1:0] {
    BANK_FREE    = 2'd0,
    BANK_FULL    = 2'd1,
    BANK_READING = 2'd2
  } bankStateT;

  // Bank bookkeeping
  bankStateT bankState     [2];
  bankStateT bankStateNext [2];

  // Write side
  logic              wrBank;
  logic [ADDR_W-1:0] wrCnt;
  logic              accept;
  logic              wrLast;

  // Read side
  logic              rdActive;
  logic              rdBank;
  logic [ADDR_W-1:0] rdCnt;
  logic              startRead;
  logic              startBank;
  logic              issue;
  logic              issueBank;
  logic [ADDR_W-1:0] issueCnt;
  logic [ADDR_W-1:0] issueAddr;
  logic              issueLast;

  // Storage and read pipeline
  logic [WORD_W-1:0] mem [2*FRAME_LEN];
  logic [WORD_W-1:0] rdData;
  logic              rdValid;
  logic              rdSof;

  assign accept    = validIn && enIn;
  assign wrLast    = accept && (wrCnt == LAST_IDX);
  assign issue     = rdActive || startRead;
  assign issueBank = rdActive ? rdBank : startBank;
  assign issueCnt  = rdActive ? rdCnt : '0;
  // Even read slots walk the lower half, odd slots the upper half.
  assign issueAddr = (issueCnt >> 1) + (issueCnt[0] ? HALF_IDX : '0);
  assign issueLast = (issueCnt == LAST_IDX);

  // Pick a FULL bank to start reading when no readout is in progress.
  always_comb begin
    startRead = 1'b0;
    startBank = 1'b0;
    if (rdActive) begin
      startRead = 1'b0;
      startBank = 1'b0;
    end else if (bankState[0] == BANK_FULL) begin
      startRead = 1'b1;
      startBank = 1'b0;
    end else if (bankState[1] == BANK_FULL) begin
      startRead = 1'b1;
      startBank = 1'b1;
    end else begin
      startRead = 1'b0;
      startBank = 1'b0;
    end
  end

  // Next bank states: a read issue owns its bank, the last write marks FULL.
  always_comb begin
    bankStateNext[0] = bankState[0];
    bankStateNext[1] = bankState[1];
    for (int b = 0; b < 2; b++) begin
      if (issue && (issueBank == 1'(b))) begin
        bankStateNext[b] = issueLast ? BANK_FREE : BANK_READING;
      end else if (wrLast && (wrBank == 1'(b))) begin
        bankStateNext[b] = BANK_FULL;
      end else begin
        bankStateNext[b] = bankState[b];
      end
    end
  end

  // Counters, bank states and the registered output stage.
  always_ff @(posedge clkIn) begin
    if (!rstIn) begin
      bankState[0] <= BANK_FREE;
      bankState[1] <= BANK_FREE;
      wrBank       <= 1'b0;
      wrCnt        <= '0;
      rdActive     <= 1'b0;
      rdBank       <= 1'b0;
      rdCnt        <= '0;
      rdValid      <= 1'b0;
      rdSof        <= 1'b0;
      dataOut      <= '0;
      validOut     <= 1'b0;
      sofOut       <= 1'b0;
    end else if (enIn) begin
      bankState[0] <= bankStateNext[0];
      bankState[1] <= bankStateNext[1];
      if (accept) begin
        wrCnt <= wrCnt + ADDR_W'(1);
        if (wrLast) begin
          wrBank <= ~wrBank;
        end
      end
      if (issue) begin
        rdActive <= ~issueLast;
        rdBank   <= issueBank;
        rdCnt    <= issueCnt + ADDR_W'(1);
        rdValid  <= 1'b1;
        rdSof    <= (issueCnt == '0);
      end else begin
        rdValid  <= 1'b0;
        rdSof    <= 1'b0;
      end
      dataOut  <= rdData;
      validOut <= rdValid;
      sofOut   <= rdSof;
    end
  end

  // Frame buffer write port; contents need no reset since valid is tracked.
  always_ff @(posedge clkIn) begin
    if (accept && rstIn) begin
      mem[{wrBank, wrCnt}] <= dataIn;
    end
  end

  // Synchronous read port, one cycle of latency ahead of the output stage.
  always_ff @(posedge clkIn) begin
    if (!rstIn) begin
      rdData <= '0;
    end else if (enIn && issue) begin
      rdData <= mem[{issueBank, issueAddr}];
    end
  end

  radix_2_pair_reorder_chk uChk (
    .clk        (clkIn),
    .rst        (rstIn),
    .accept     (accept),
    .targetFree (bankState[wrBank] == BANK_FREE)
  );

endmodule

// Overrun watchdog: an accepted sample must always land in a FREE bank.
module radix_2_pair_reorder_chk (
  input logic clk,
  input logic rst,
  input logic accept,
  input logic targetFree
);

  // Flag any write into a bank that is still FULL or being read.
  always_ff @(posedge clk) begin
    if (rst && accept) begin
      assert (targetFree) else $error("radix_2_pair_reorder overrun: write into non-free bank");
    end
  end

endmodule
